ldl_cdc_ring_tx_sched: RTL and testbench

//  Round-robin scheduler sharing one CDC ring channel (tx side) among N requesters.
//  - Grants one requester at a time and latches its payload plus requester id and sequence bit.
//  - Holds the latched word stable on ring_din for HOLD cycles, so the ring's toggle

---
 rtl/ldl_cdc_ring_tx_sched.sv | 101 ++++++++++
 tb/tb_ldl_cdc_ring_tx_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldl_cdc_ring_tx_sched.sv
// rtl/ldl_cdc_ring_tx_sched.sv - round-robin scheduler feeding one CDC ring tx channel
// Grants one requester, latches {seq, id, data} onto the ring and holds it HOLD cycles.
module ldl_cdc_ring_tx_sched #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int HOLD  = 8,
  localparam int IDW  = $clog2(N)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic [N-1:0]         i_req,
  input  logic [N*WIDTH-1:0]   i_req_data,
  output logic [N-1:0]         o_gnt,
  output logic [IDW+WIDTH:0]   o_ring_din,
  output logic                 o_busy
);

  localparam int CW = $clog2(HOLD);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [IDW-1:0]     r_ptr, w_ptr_nxt;
  logic               r_seq, w_seq_nxt;
  logic [N-1:0]       r_gnt, w_gnt_nxt;
  logic [IDW+WIDTH:0] r_din, w_din_nxt;
  logic               r_busy, w_busy_nxt;
  logic               w_found;
  logic [IDW-1:0]     w_win;

  // Linear scan starting at the round-robin pointer; first requester found wins.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!w_found && i_req[idx]) begin
        w_found = 1'b1;
        w_win   = IDW'(idx);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_seq_nxt   = r_seq;
    w_gnt_nxt   = '0;
    w_din_nxt   = r_din;
    w_busy_nxt  = r_busy;
    if (r_state == S_IDLE) begin
      if (i_en && w_found) begin
        w_state_nxt = S_HOLD;
        w_din_nxt   = {~r_seq, w_win, i_req_data[int'(w_win)*WIDTH +: WIDTH]};
        w_seq_nxt   = ~r_seq;
        w_gnt_nxt   = N'(1) << w_win;
        w_ptr_nxt   = (int'(w_win) == N-1) ? '0 : w_win + IDW'(1);
        w_cnt_nxt   = CW'(HOLD-1);
        w_busy_nxt  = 1'b1;
      end
    end else begin
      if (r_cnt != '0) begin
        w_cnt_nxt = r_cnt - CW'(1);
      end else begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_seq   <= 1'b0;
      r_gnt   <= '0;
      r_din   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_seq   <= w_seq_nxt;
      r_gnt   <= w_gnt_nxt;
      r_din   <= w_din_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign o_gnt      = r_gnt;
  assign o_ring_din = r_din;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_ldl_cdc_ring_tx_sched.sv
// tb/tb_ldl_cdc_ring_tx_sched.sv - scoreboard bench for the ring tx scheduler
// Stimulus drives requesters and a reference model; a monitor pops expected grants.
module tb_ldl_cdc_ring_tx_sched;
  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int HOLD  = 8;
  localparam int IDW   = $clog2(N);
  localparam int DW    = 1 + IDW + WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*WIDTH-1:0] req_data = '0;
  logic [N-1:0]     gnt;
  logic [DW-1:0]    ring_din;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int             at;
    int             id;
    logic [WIDTH-1:0] data;
    logic           seq;
  } exp_t;
  exp_t q[$];

  int   m_ptr = 0;
  logic m_seq = 1'b0;
  int   m_free = 0;

  ldl_cdc_ring_tx_sched #(.N(N), .WIDTH(WIDTH), .HOLD(HOLD)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_req(req), .i_req_data(req_data),
    .o_gnt(gnt), .o_ring_din(ring_din), .o_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: an idle scheduler grants the first requester at or after the pointer.
  task automatic model();
    exp_t e;
    bit   found;
    if (rst) begin
      q.delete();
      m_seq  = 1'b0;
      m_ptr  = 0;
      m_free = cyc + 1;
    end else if (cyc >= m_free && en && (req != '0)) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int id;
        id = (m_ptr + k) % N;
        if (!found && req[id]) begin
          found  = 1;
          m_seq  = ~m_seq;
          e.at   = cyc + 1;
          e.id   = id;
          e.data = req_data[id*WIDTH +: WIDTH];
          e.seq  = m_seq;
          q.push_back(e);
          m_ptr  = (id + 1) % N;
          m_free = cyc + 1 + HOLD;
        end
      end
    end
  endtask

  task automatic adv();
    model();
    @(posedge clk);
    #2;
  endtask

  function automatic int gnt_id(input logic [N-1:0] g);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  // Monitor: samples 1 time unit after each edge, before stimulus changes inputs.
  initial begin
    int busy_until;
    int waits[N];
    logic [DW-1:0] last_din;
    exp_t e;
    busy_until = -1;
    last_din   = '0;
    for (int i = 0; i < N; i++) waits[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_din", 32'(ring_din), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        busy_until = -1;
        last_din   = '0;
        for (int i = 0; i < N; i++) waits[i] = 0;
      end else begin
        while (q.size() > 0 && q[0].at < cyc) begin
          chk("missed_grant", 32'(q[0].at), 32'(cyc));
          void'(q.pop_front());
        end
        if (gnt != '0) begin
          if (q.size() == 0 || q[0].at != cyc) begin
            chk("unexpected_grant", 32'(gnt), 32'd0);
          end else begin
            e = q.pop_front();
            chk("grant_onehot", 32'(gnt), 32'(1) << e.id);
            chk("ring_din", 32'(ring_din), 32'({e.seq, IDW'(e.id), e.data}));
            busy_until = cyc + HOLD - 1;
            for (int i = 0; i < N; i++) begin
              if (i == e.id) begin
                chk("starvation", 32'(waits[i] <= N-1), 32'd1);
                waits[i] = 0;
              end else if (req[i]) begin
                waits[i]++;
              end
            end
          end
        end else begin
          chk("din_stable", 32'(ring_din), 32'(last_din));
        end
        for (int i = 0; i < N; i++) if (!req[i]) waits[i] = 0;
        last_din = ring_din;
        chk("busy", 32'(busy), 32'(cyc <= busy_until));
      end
    end
  end

  initial begin
    int ids[5];
    int ats[5];
    logic [DW-1:0] dins[5];
    int n;
    #2;
    repeat (3) adv();
    rst = 1'b0;

    // Single requester 2 with 0xA5.
    req = 4'b0100;
    req_data[2*WIDTH +: WIDTH] = 8'hA5;
    en = 1'b1;
    adv();
    chk("t1_gnt", 32'(gnt), 32'h4);
    chk("t1_din", 32'(ring_din), 32'h6A5);
    req = '0;
    repeat (12) adv();

    // All requesting continuously from a fresh reset.
    rst = 1'b1;
    adv();
    rst = 1'b0;
    for (int i = 0; i < N; i++) req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    req = '1;
    n = 0;
    for (int c = 0; c < 80 && n < 5; c++) begin
      adv();
      if (gnt != '0) begin
        ids[n] = gnt_id(gnt);
        ats[n] = cyc;
        dins[n] = ring_din;
        n++;
      end
    end
    chk("t2_count", 32'(n), 32'd5);
    if (n == 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("t2_order", 32'(ids[k]), 32'(k % N));
        chk("t2_seq", 32'(dins[k][DW-1]), 32'((k % 2) == 0));
        if (k > 0) chk("t2_spacing", 32'(ats[k] - ats[k-1]), 32'(HOLD + 1));
      end
    end
    req = '0;
    repeat (12) adv();

    // Same payload twice from requester 1.
    req = 4'b0010;
    req_data[1*WIDTH +: WIDTH] = 8'h3C;
    n = 0;
    for (int c = 0; c < 40 && n < 2; c++) begin
      adv();
      if (gnt != '0) begin
        dins[n] = ring_din;
        n++;
      end
    end
    chk("t3_count", 32'(n), 32'd2);
    if (n == 2) begin
      chk("t3_payload", 32'(dins[1][WIDTH-1:0]), 32'h3C);
      chk("t3_seq_differs", 32'(dins[0][DW-1] ^ dins[1][DW-1]), 32'd1);
    end
    req = '0;
    repeat (12) adv();

    // Enable gating.
    en = 1'b0;
    req = 4'b0001;
    req_data[0 +: WIDTH] = 8'h11;
    repeat (6) adv();
    chk("t4_no_gnt", 32'(gnt), 32'd0);
    en = 1'b1;
    adv();
    chk("t4_gnt0", 32'(gnt), 32'd1);
    en = 1'b0;
    repeat (15) adv();
    req = '0;
    en = 1'b1;
    repeat (3) adv();

    // Reset in the third HOLD cycle with requesters 3 and 0 pending.
    req = 4'b1001;
    req_data[0 +: WIDTH] = 8'h5A;
    req_data[3*WIDTH +: WIDTH] = 8'hC3;
    n = 0;
    for (int c = 0; c < 20 && n == 0; c++) begin
      adv();
      if (gnt != '0) n = 1;
    end
    chk("t5_first_grant", 32'(n), 32'd1);
    adv();
    adv();
    rst = 1'b1;
    adv();
    rst = 1'b0;
    chk("t5_din_zero", 32'(ring_din), 32'd0);
    chk("t5_busy_zero", 32'(busy), 32'd0);
    adv();
    chk("t5_req0_wins", 32'(gnt), 32'd1);
    req = '0;
    repeat (12) adv();

    // Randomised traffic.
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && gnt[i]) begin
          if ($urandom_range(1, 0) == 1) req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
          else req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(3, 0) == 0) begin
            req[i] = 1'b1;
            req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
          end
        end else if ($urandom_range(63, 0) == 0) begin
          req[i] = 1'b0;
        end
      end
      en  = ($urandom_range(15, 0) != 0);
      rst = ($urandom_range(999, 0) == 0);
      adv();
    end
    rst = 1'b0;
    req = '0;
    en  = 1'b0;
    repeat (20) adv();
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
